// File: rtl/iq_upmixer.sv
// I/Q up-mixer: out = I*cos(ph) - Q*sin(ph) from a 32-bit NCO, quarter-wave ROM and zero-order-hold input.
// Define IQ_UPMIX_SATURATE_EN to clamp the output and count clamp events on ovf_count.
module iq_upmixer #(
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 14,
  parameter int LUT_AW    = 10,
  parameter int RATE      = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [31:0]                 phase_inc,
  input  logic                        phase_load,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [IN_WIDTH-1:0]  in_i,
  input  logic signed [IN_WIDTH-1:0]  in_q,
  output logic                        out_valid,
  output logic signed [OUT_WIDTH-1:0] out_data,
  output logic                        underflow,
  output logic [15:0]                 ovf_count
);
  localparam int N   = 1 << LUT_AW;
  localparam int CW  = (RATE > 1) ? $clog2(RATE) : 1;
  localparam int PW  = IN_WIDTH + 18;
  localparam int DW  = PW + 1;
  localparam int SH  = PW - OUT_WIDTH - 1;
  localparam int SHP = (SH > 0) ? SH : 0;
  localparam int SHL = (SH > 0) ? 0 : -SH;
  localparam int RW  = OUT_WIDTH + 2;
  localparam logic signed [DW-1:0] RND = DW'((longint'(1) <<< SHP) >>> 1);

  // round(131071*sin(pi/2*k/N)) via a Q30 Taylor series, evaluated at elaboration
  function automatic logic [16:0] sin_q17(input int k);
    longint x, x2, term, acc;
    x    = (longint'(1686629713) * longint'(k)) / longint'(N);
    x2   = (x * x) >>> 30;
    term = x;
    acc  = x;
    for (int n = 1; n < 10; n++) begin
      term = -((term * x2) >>> 30) / longint'((2 * n) * (2 * n + 1));
      acc  = acc + term;
    end
    return 17'((acc * longint'(131071) + (longint'(1) <<< 29)) >>> 30);
  endfunction

  logic [16:0] rom [0:N];
  for (genvar gi = 0; gi <= N; gi++) begin : g_rom
    assign rom[gi] = sin_q17(gi);
  end

  logic [CW-1:0]              cnt_reg;
  logic [31:0]                phase_acc_reg;
  logic signed [IN_WIDTH-1:0] hold_i_reg, hold_q_reg, i_reg, q_reg;
  logic signed [17:0]         sin_reg, cos_reg, sin_next, cos_next;
  logic signed [PW-1:0]       pi_reg, pq_reg;
  logic signed [OUT_WIDTH-1:0] data_reg, fit_next;
  logic [2:0]                 vsr_reg;
  logic                       underflow_reg;
  logic                       slot;
  logic [1:0]                 qd;
  logic [LUT_AW-1:0]          a;
  logic [LUT_AW:0]            a_rev;
  logic signed [17:0]         tf, tr;
  logic signed [DW-1:0]       d_val;
  logic signed [DW+SHL-1:0]   sum_val;

  assign slot      = (cnt_reg == CW'(RATE - 1));
  assign in_ready  = slot & ~reset;
  assign out_valid = vsr_reg[2];
  assign out_data  = data_reg;
  assign underflow = underflow_reg;

  assign qd    = phase_acc_reg[31:30];
  assign a     = phase_acc_reg[29 -: LUT_AW];
  assign a_rev = (LUT_AW + 1)'(N) - {1'b0, a};
  assign tf    = $signed({1'b0, rom[{1'b0, a}]});
  assign tr    = $signed({1'b0, rom[a_rev]});

  // Quadrant fold of the quarter-wave table into full sin/cos
  always_comb begin
    sin_next = '0;
    cos_next = '0;
    case (qd)
      2'd0:    begin sin_next = tf;  cos_next = tr;  end
      2'd1:    begin sin_next = tr;  cos_next = -tf; end
      2'd2:    begin sin_next = -tf; cos_next = -tr; end
      default: begin sin_next = -tr; cos_next = tf;  end
    endcase
  end

  assign d_val   = DW'(pi_reg) - DW'(pq_reg);
  assign sum_val = (DW + SHL)'(d_val + RND) <<< SHL;

`ifdef IQ_UPMIX_SATURATE_EN
  localparam logic signed [RW-1:0] OMAX = RW'((longint'(1) <<< (OUT_WIDTH - 1)) - 1);
  localparam logic signed [RW-1:0] OMIN = RW'(-(longint'(1) <<< (OUT_WIDTH - 1)));
  logic signed [RW-1:0] r_val;
  logic                 clamp;
  logic [15:0]          ovf_reg;

  assign r_val = RW'(sum_val >>> SHP);

  always_comb begin
    fit_next = r_val[OUT_WIDTH-1:0];
    clamp    = 1'b0;
    if (r_val > OMAX) begin
      fit_next = OMAX[OUT_WIDTH-1:0];
      clamp    = 1'b1;
    end else if (r_val < OMIN) begin
      fit_next = OMIN[OUT_WIDTH-1:0];
      clamp    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) ovf_reg <= '0;
    else if (clamp && ovf_reg != 16'hFFFF) ovf_reg <= ovf_reg + 16'd1;
  end
  assign ovf_count = ovf_reg;
`else
  assign fit_next  = OUT_WIDTH'(sum_val >>> SHP);
  assign ovf_count = 16'd0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg       <= '0;
      phase_acc_reg <= '0;
      hold_i_reg    <= '0;
      hold_q_reg    <= '0;
      underflow_reg <= 1'b0;
      sin_reg       <= '0;
      cos_reg       <= '0;
      i_reg         <= '0;
      q_reg         <= '0;
      pi_reg        <= '0;
      pq_reg        <= '0;
      data_reg      <= '0;
      vsr_reg       <= '0;
    end else begin
      cnt_reg       <= slot ? '0 : cnt_reg + CW'(1);
      phase_acc_reg <= phase_load ? 32'd0 : phase_acc_reg + phase_inc;
      if (slot) begin
        hold_i_reg <= in_valid ? in_i : '0;
        hold_q_reg <= in_valid ? in_q : '0;
        if (!in_valid) underflow_reg <= 1'b1;
      end
      sin_reg  <= sin_next;
      cos_reg  <= cos_next;
      i_reg    <= hold_i_reg;
      q_reg    <= hold_q_reg;
      pi_reg   <= PW'(i_reg) * PW'(cos_reg);
      pq_reg   <= PW'(q_reg) * PW'(sin_reg);
      data_reg <= fit_next;
      vsr_reg  <= {vsr_reg[1:0], 1'b1};
    end
  end
endmodule
